// File: rtl/seg_pkg.sv
// seg_pkg: shared types and the seven-segment decode table for seg_capture.
// Segment bus is active-low, bit0 = a .. bit6 = g.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Entry n is the segment pattern that displays hex digit n.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational segment-pattern to nibble decoder.
// is_valid covers both hex patterns and the all-off blank pattern.
module seg_decode
  import seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_valid
);

  // Table lookup; blank decodes as nibble 0.
  always_comb begin
    nibble   = 4'h0;
    is_blank = (seg == SEG_BLANK);
    is_valid = is_blank;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble   = 4'(i);
        is_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed seven-segment display, debounces each
// digit for STABLE_CYCLES samples and reports changed digits as events.
// Optional feature: define SEG_CAPTURE_ERR_EN to add err / err_cnt reporting
// of invalid committed patterns.
module seg_capture
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [IW-1:0]           ev_idx,
  output logic [3:0]              ev_nibble,
  output logic                    ev_blank,
  output logic                    overrun,
`ifdef SEG_CAPTURE_ERR_EN
  output logic                    err,
  output logic [7:0]              err_cnt,
`endif
  input  logic                    clr_overrun
);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        ref_idx_q, ref_idx_d;
  seg_t                 ref_seg_q, ref_seg_d;
  logic                 sel_onehot, same, commit;
  logic [IW-1:0]        sel_idx;
  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [3:0]           dec_nib;
  logic                 dec_blank, dec_valid;
  logic                 hex_commit, blank_commit, new_ev;

  assign digits = digits_q;

  // Strobe legality and index of the active digit.
  always_comb begin
    sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    sel_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_sel[i]) sel_idx = IW'(i);
  end

  assign same   = (sel_idx == ref_idx_q) && (seg == ref_seg_q);
  // The reference already held for STABLE_CYCLES samples, so it is accepted
  // even if the input moves during this cycle.
  assign commit = (state_q == ST_SETTLE) && (cnt_q == CW'(STABLE_CYCLES));

  // Next-state, stability counter and reference capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_idx_d = ref_idx_q;
    ref_seg_d = ref_seg_q;
    if (!sel_onehot) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ref_idx_d = sel_idx;
          ref_seg_d = seg;
          cnt_d     = CW'(1);
          state_d   = ST_SETTLE;
        end
        ST_SETTLE, ST_LOCKED: begin
          if (!same) begin
            ref_idx_d = sel_idx;
            ref_seg_d = seg;
            cnt_d     = CW'(1);
            state_d   = ST_SETTLE;
          end else if (commit) begin
            state_d = ST_LOCKED;
          end else if (state_q == ST_SETTLE) begin
            cnt_d = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM, counter and reference registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ref_idx_q <= '0;
      ref_seg_q <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_idx_q <= ref_idx_d;
      ref_seg_q <= ref_seg_d;
    end
  end

  seg_decode u_dec (
    .seg      (ref_seg_q),
    .nibble   (dec_nib),
    .is_blank (dec_blank),
    .is_valid (dec_valid)
  );

  assign hex_commit   = commit && dec_valid && !dec_blank;
  assign blank_commit = commit && dec_blank;
  assign new_ev = (hex_commit && (blank[ref_idx_q] || digits_q[ref_idx_q] != dec_nib))
               || (blank_commit && !blank[ref_idx_q]);

  // Per-digit accepted value; a blank commit keeps the old nibble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      blank    <= '1;
    end else if (hex_commit) begin
      digits_q[ref_idx_q] <= dec_nib;
      blank[ref_idx_q]    <= 1'b0;
    end else if (blank_commit) begin
      blank[ref_idx_q]    <= 1'b1;
    end
  end

  // Single-entry event slot: accept when empty or draining, else drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid  <= 1'b0;
      ev_idx    <= '0;
      ev_nibble <= '0;
      ev_blank  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (new_ev && (!ev_valid || ev_ready)) begin
        ev_valid  <= 1'b1;
        ev_idx    <= ref_idx_q;
        ev_nibble <= dec_nib;
        ev_blank  <= dec_blank;
      end else if (ev_valid && ev_ready) begin
        ev_valid  <= 1'b0;
      end
      if (new_ev && ev_valid && !ev_ready) overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
    end
  end

`ifdef SEG_CAPTURE_ERR_EN
  logic bad_commit;
  assign bad_commit = commit && !dec_valid;

  // Sticky error flag and saturating count of invalid accepted patterns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (bad_commit)       err <= 1'b1;
      else if (clr_overrun) err <= 1'b0;
      if (bad_commit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (NUM_DIGITS=4, STABLE_CYCLES=16).
// Err checks are active when SEG_CAPTURE_ERR_EN is defined.
module tb_seg_capture;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        ev_valid, ev_ready, ev_blank, overrun, clr_overrun;
  logic [1:0]  ev_idx;
  logic [3:0]  ev_nibble;
`ifdef SEG_CAPTURE_ERR_EN
  logic        err;
  logic [7:0]  err_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  localparam logic [6:0] P0 = 7'b1000000, P2 = 7'b0100100, P3 = 7'b0110000,
                         P5 = 7'b0010010, P7 = 7'b1111000, P8 = 7'b0000000,
                         PA = 7'b0001000, P1 = 7'b1111001, PB = 7'b1111111,
                         PBAD = 7'b1010101, PGL = 7'b0110001;

  seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .seg(seg), .dig_sel(dig_sel),
    .digits(digits), .blank(blank), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_idx(ev_idx), .ev_nibble(ev_nibble), .ev_blank(ev_blank),
    .overrun(overrun),
`ifdef SEG_CAPTURE_ERR_EN
    .err(err), .err_cnt(err_cnt),
`endif
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; seg = PB; dig_sel = 4'b0000; ev_ready = 1'b0; clr_overrun = 1'b0;
    step(2);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_blank", blank, 4'b1111);
    chk("rst_evv", ev_valid, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    reset_n = 1'b1;
    step(1);

    // First acceptance of '2' on digit0: visible 17 edges after it appears.
    dig_sel = 4'b0001; seg = P2;
    step(16);
    chk("d0_early_digits", digits, 16'h0000);
    chk("d0_early_evv", ev_valid, 1'b0);
    step(1);
    chk("d0_digits", digits, 16'h0002);
    chk("d0_blank", blank, 4'b1110);
    chk("d0_evv", ev_valid, 1'b1);
    chk("d0_evidx", ev_idx, 2'd0);
    chk("d0_evnib", ev_nibble, 4'h2);
    chk("d0_evblank", ev_blank, 1'b0);
    ev_ready = 1'b1;
    step(1);
    chk("d0_drain", ev_valid, 1'b0);
    step(5);
    chk("d0_locked_noev", ev_valid, 1'b0);

    // Multi-hot strobes never commit.
    dig_sel = 4'b0011; seg = P1;
    step(20);
    chk("mh_state", dut.state_q, ST_IDLE);
    chk("mh_digits", digits, 16'h0002);
    chk("mh_evv", ev_valid, 1'b0);

    // Glitch restarts the stability window.
    dig_sel = 4'b0010; seg = P3;
    step(9);
    seg = PGL;
    step(1);
    seg = P3;
    step(16);
    chk("gl_early", digits, 16'h0002);
    chk("gl_early_evv", ev_valid, 1'b0);
    step(1);
    chk("gl_digits", digits, 16'h0032);
    chk("gl_evv", ev_valid, 1'b1);
    chk("gl_evidx", ev_idx, 2'd1);
    chk("gl_evnib", ev_nibble, 4'h3);
    step(1);
    chk("gl_drain", ev_valid, 1'b0);

    // Overrun: second event dropped while the first is unacknowledged.
    ev_ready = 1'b0;
    seg = PA;
    step(17);
    chk("ov_first_evv", ev_valid, 1'b1);
    chk("ov_first_nib", ev_nibble, 4'hA);
    dig_sel = 4'b0100; seg = P5;
    step(17);
    chk("ov_digits", digits, 16'h05A2);
    chk("ov_evidx", ev_idx, 2'd1);
    chk("ov_evnib", ev_nibble, 4'hA);
    chk("ov_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("ov_clr", overrun, 1'b0);
    chk("ov_still_pending", ev_valid, 1'b1);
    ev_ready = 1'b1;
    step(1);
    chk("ov_drain", ev_valid, 1'b0);

    // Digit3: 7 then blank keeps the nibble and raises a blank event.
    dig_sel = 4'b1000; seg = P7;
    step(17);
    chk("b3_digits7", digits, 16'h75A2);
    chk("b3_evidx7", ev_idx, 2'd3);
    chk("b3_blank7", blank, 4'b0000);
    step(1);
    seg = PB;
    step(17);
    chk("b3_blank", blank, 4'b1000);
    chk("b3_digits", digits, 16'h75A2);
    chk("b3_evv", ev_valid, 1'b1);
    chk("b3_evblank", ev_blank, 1'b1);
    chk("b3_evidx", ev_idx, 2'd3);
    step(1);

    // Identical recommit produces no event.
    dig_sel = 4'b0001; seg = P2;
    step(17);
    chk("same_noev", ev_valid, 1'b0);
    chk("same_digits", digits, 16'h75A2);

    // Invalid pattern is held off the outputs.
    seg = PBAD;
    step(17);
    chk("bad_digits", digits, 16'h75A2);
    chk("bad_blank", blank, 4'b1000);
    chk("bad_noev", ev_valid, 1'b0);
`ifdef SEG_CAPTURE_ERR_EN
    chk("bad_err", err, 1'b1);
    chk("bad_errcnt", err_cnt, 8'd1);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("bad_errclr", err, 1'b0);
    chk("bad_errcnt_hold", err_cnt, 8'd1);
`endif

    // Reset with an event pending and a digit mid-settle.
    ev_ready = 1'b0;
    dig_sel = 4'b0010; seg = P0;
    step(17);
    chk("pr_evv", ev_valid, 1'b1);
    chk("pr_evnib", ev_nibble, 4'h0);
    dig_sel = 4'b0100; seg = P8;
    step(5);
    reset_n = 1'b0;
    #1;
    chk("ar_digits", digits, 16'h0000);
    chk("ar_blank", blank, 4'b1111);
    chk("ar_evv", ev_valid, 1'b0);
    chk("ar_evidx", ev_idx, 2'd0);
    chk("ar_evnib", ev_nibble, 4'h0);
    chk("ar_ovr", overrun, 1'b0);
    chk("ar_state", dut.state_q, ST_IDLE);
    chk("ar_cnt", dut.cnt_q, 0);
`ifdef SEG_CAPTURE_ERR_EN
    chk("ar_err", err, 1'b0);
    chk("ar_errcnt", err_cnt, 8'd0);
`endif
    reset_n = 1'b1;
    dig_sel = 4'b0000;
    step(3);
    chk("post_evv", ev_valid, 1'b0);
    chk("post_digits", digits, 16'h0000);
    dig_sel = 4'b0001; seg = P2;
    step(17);
    chk("post_fresh_evv", ev_valid, 1'b1);
    chk("post_fresh_nib", ev_nibble, 4'h2);
    chk("post_fresh_digits", digits, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
